// File: rtl/phase_ctrl_pkg.sv
// Shared definitions for the clock-phase select controller: FSM state
// encoding and constant-function helpers used to size buses and counters.
package phase_ctrl_pkg;

    // Controller modes; encoding 2'b11 is illegal and recovers to TRACK.
    typedef enum logic [1:0] {
        ST_TRACK = 2'b00,
        ST_HOLD  = 2'b01,
        ST_FORCE = 2'b10
    } state_e;

    // Number of bits needed to encode values 0..value-1 (ceil(log2(value))).
    function automatic int f_clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

    // Larger of two integers.
    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/phase_sel_cnt.sv
// Saturating up-counter with synchronous clear. The terminal-count flag is
// raised one step early: it says "the next increment lands on MAX", so the
// controller can act in the same cycle the threshold is reached.
module phase_sel_cnt #(
    parameter int W   = 4,
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_tc
);

    localparam logic [W:0] MAX_V = (W + 1)'(MAX);

    logic [W-1:0] r_cnt;
    logic [W:0]   w_cnt_ext;
    logic         w_at_max;

    assign w_cnt_ext = {1'b0, r_cnt};
    assign w_at_max  = (w_cnt_ext == MAX_V);
    assign o_tc      = ((w_cnt_ext + (W + 1)'(1)) >= MAX_V);

    // Count on the falling edge; clear has priority, saturate at MAX.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block order.
            r_cnt <= '0;
        end else if (i_inc && !w_at_max) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/phase_sel_ctrl.sv
// N-phase clock-select controller for the timing-error recovery path.
// Steps the selected phase earlier on persistent error, back toward the
// origin phase after a clean interval, with post-switch hold-off, sticky
// saturation reporting and a forced-select override. All state updates on
// the falling edge of clk; every output is registered.
module phase_sel_ctrl
    import phase_ctrl_pkg::*;
#(
    parameter  int NUM_PHASES  = 3,
    parameter  int ORIGIN_IDX  = 1,
    parameter  int ERR_THRESH  = 2,
    parameter  int RECOVER_CNT = 8,
    parameter  int HOLDOFF     = 4,
    localparam int SEL_W       = f_max(1, f_clog2(NUM_PHASES))
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_PHASES-1:0] error_vec,
    input  logic                  auto_en,
    input  logic [SEL_W-1:0]      force_sel,
    input  logic                  err_sat_clr,
    output logic [SEL_W-1:0]      clk_sel,
    output logic                  switch_pulse,
    output logic                  err_sat,
    output logic [1:0]            state_o
);

    localparam int               CNT_W      = f_clog2(f_max(f_max(ERR_THRESH, RECOVER_CNT), HOLDOFF) + 1);
    localparam logic [SEL_W-1:0] ORIGIN_SEL = SEL_W'(ORIGIN_IDX);
    localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(NUM_PHASES - 1);
    localparam logic [SEL_W:0]   LAST_EXT   = (SEL_W + 1)'(NUM_PHASES - 1);

    state_e               r_state;
    logic [SEL_W-1:0]     r_clk_sel;
    logic                 r_switch_pulse;
    logic                 r_err_sat;

    logic [NUM_PHASES-1:0] w_sel_onehot;
    logic                  w_err;
    logic [SEL_W-1:0]      w_force_sel;
    logic                  w_track;
    logic                  w_hold;
    logic                  w_err_tc;
    logic                  w_clean_tc;
    logic                  w_hold_tc;
    logic                  w_err_hit;
    logic                  w_rec_hit;
    logic                  w_err_inc;
    logic                  w_clean_inc;
    logic                  w_hold_inc;

    // Only the error flag of the currently selected phase matters.
    assign w_sel_onehot = NUM_PHASES'(1) << r_clk_sel;
    assign w_err        = |(error_vec & w_sel_onehot);

    // Automatic tracking is active only with auto_en high; otherwise the
    // FSM is (or is about to be) in FORCE and all counters stay cleared.
    assign w_track = auto_en && (r_state == ST_TRACK);
    assign w_hold  = auto_en && (r_state == ST_HOLD);

    // Threshold events: error wins over recovery in the same cycle, and
    // recovery never steps later than the origin phase.
    assign w_err_hit = w_err && w_err_tc;
    assign w_rec_hit = !w_err && w_clean_tc && (r_clk_sel < ORIGIN_SEL);

    // Clamp out-of-range forced selects to the most lagging phase.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        w_force_sel = force_sel;
        if ({1'b0, force_sel} > LAST_EXT) begin
            w_force_sel = LAST_SEL;
        end
    end

    // Counter control: each counter advances only in its qualifying
    // situation and is cleared in every other cycle, including on the
    // threshold event that consumes it.
    always_comb begin
        w_err_inc   = w_track && w_err && !w_err_tc;
        w_clean_inc = w_track && !w_err && !w_rec_hit;
        w_hold_inc  = w_hold && !w_hold_tc;
    end

    // Consecutive errors on the selected phase.
    phase_sel_cnt #(
        .W   (CNT_W),
        .MAX (ERR_THRESH)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (!w_err_inc),
        .i_inc (w_err_inc),
        .o_tc  (w_err_tc)
    );

    // Consecutive clean cycles; saturates at RECOVER_CNT at or past origin.
    phase_sel_cnt #(
        .W   (CNT_W),
        .MAX (RECOVER_CNT)
    ) u_clean_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (!w_clean_inc),
        .i_inc (w_clean_inc),
        .o_tc  (w_clean_tc)
    );

    // Hold-off cycle counter: counts 0..HOLDOFF, so HOLD spans HOLDOFF+1 cycles.
    phase_sel_cnt #(
        .W   (CNT_W),
        .MAX (HOLDOFF + 1)
    ) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (!w_hold_inc),
        .i_inc (w_hold_inc),
        .o_tc  (w_hold_tc)
    );

    // Mode FSM with registered select, switch pulse and sticky saturation flag.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_TRACK;
            r_clk_sel      <= ORIGIN_SEL;
            r_switch_pulse <= 1'b0;
            r_err_sat      <= 1'b0;
        end else begin
            r_switch_pulse <= 1'b0;
            if (err_sat_clr) begin
                r_err_sat <= 1'b0;
            end

            if (!auto_en) begin
                r_state        <= ST_FORCE;
                r_clk_sel      <= w_force_sel;
                r_switch_pulse <= (w_force_sel != r_clk_sel);
            end else begin
                case (r_state)
                    ST_TRACK: begin
                        if (w_err_hit) begin
                            if (r_clk_sel != '0) begin
                                r_clk_sel      <= r_clk_sel - SEL_W'(1);
                                r_switch_pulse <= 1'b1;
                                r_state        <= ST_HOLD;
                            end else begin
                                // NOTE: the later non-blocking assignment wins,
                                // so a set here overrides a same-cycle clear.
                                r_err_sat <= 1'b1;
                            end
                        end else if (w_rec_hit) begin
                            r_clk_sel      <= r_clk_sel + SEL_W'(1);
                            r_switch_pulse <= 1'b1;
                            r_state        <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (w_hold_tc) begin
                            r_state <= ST_TRACK;
                        end
                    end
                    ST_FORCE: begin
                        // Leaving forced mode keeps the current phase.
                        r_state <= ST_HOLD;
                    end
                    default: begin
                        r_state        <= ST_TRACK;
                        r_clk_sel      <= ORIGIN_SEL;
                        r_switch_pulse <= (r_clk_sel != ORIGIN_SEL);
                    end
                endcase
            end
        end
    end

    assign clk_sel      = r_clk_sel;
    assign switch_pulse = r_switch_pulse;
    assign err_sat      = r_err_sat;
    assign state_o      = r_state;

endmodule

// File: tb/tb_phase_sel_ctrl.sv
// Self-checking bench for phase_sel_ctrl with default parameters: directed
// scenarios followed by randomized traffic, all compared every cycle against
// a behavioural model of the selection rules.
module tb_phase_sel_ctrl;

    localparam int NP       = 3;
    localparam int ORIGIN   = 1;
    localparam int ETH      = 2;
    localparam int RCV      = 8;
    localparam int HOLD_N   = 4;

    logic          clk;
    logic          rst;
    logic [NP-1:0] error_vec;
    logic          auto_en;
    logic [1:0]    force_sel;
    logic          err_sat_clr;
    logic [1:0]    clk_sel;
    logic          switch_pulse;
    logic          err_sat;
    logic [1:0]    state_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: mode 0=track, 1=hold, 2=force.
    int m_sel, m_mode, m_err, m_clean, m_hold;
    bit m_sat, m_pulse;

    phase_sel_ctrl #(
        .NUM_PHASES  (NP),
        .ORIGIN_IDX  (ORIGIN),
        .ERR_THRESH  (ETH),
        .RECOVER_CNT (RCV),
        .HOLDOFF     (HOLD_N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .error_vec    (error_vec),
        .auto_en      (auto_en),
        .force_sel    (force_sel),
        .err_sat_clr  (err_sat_clr),
        .clk_sel      (clk_sel),
        .switch_pulse (switch_pulse),
        .err_sat      (err_sat),
        .state_o      (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_sel = ORIGIN; m_mode = 0; m_err = 0; m_clean = 0; m_hold = 0;
        m_sat = 0; m_pulse = 0;
    endtask

    // One falling-edge decision of the controller, from the rules directly.
    task automatic model_step(input logic [NP-1:0] ev, input logic ae,
                              input logic [1:0] fs, input logic clr);
        int old_sel;
        bit set_sat;
        old_sel = m_sel;
        set_sat = 0;
        if (!ae) begin
            m_mode = 2;
            m_sel  = (int'(fs) > NP - 1) ? NP - 1 : int'(fs);
        end else if (m_mode == 0) begin
            if (ev[m_sel]) begin
                m_clean = 0;
                m_err++;
                if (m_err == ETH) begin
                    m_err = 0;
                    if (m_sel > 0) begin
                        m_sel--; m_mode = 1; m_hold = 0;
                    end else begin
                        set_sat = 1;
                    end
                end
            end else begin
                m_err = 0;
                if (m_clean < RCV) m_clean++;
                if (m_clean == RCV && m_sel < ORIGIN) begin
                    m_sel++; m_mode = 1; m_hold = 0;
                end
            end
        end else if (m_mode == 1) begin
            if (m_hold == HOLD_N) m_mode = 0;
            else m_hold++;
        end else begin
            m_mode = 1; m_hold = 0;
        end
        if (m_mode != 0) begin m_err = 0; m_clean = 0; end
        if (m_mode == 2) m_hold = 0;
        if (clr) m_sat = 0;
        if (set_sat) m_sat = 1;
        m_pulse = (m_sel != old_sel);
    endtask

    task automatic compare_all();
        check("clk_sel", 32'(clk_sel), 32'(m_sel));
        check("switch_pulse", 32'(switch_pulse), 32'(m_pulse));
        check("err_sat", 32'(err_sat), 32'(m_sat));
        check("state_o", 32'(state_o), 32'(m_mode));
    endtask

    // Called just after a rising edge: drive, let one falling edge act,
    // then compare on the following rising edge.
    task automatic cycle(input logic [NP-1:0] ev, input logic ae,
                         input logic [1:0] fs, input logic clr);
        error_vec   = ev;
        auto_en     = ae;
        force_sel   = fs;
        err_sat_clr = clr;
        model_step(ev, ae, fs, clr);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic run_clean(input int n);
        for (int i = 0; i < n; i++) cycle('0, 1'b1, 2'd0, 1'b0);
    endtask

    // Asynchronous reset asserted between edges; outputs must change at once.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_sel"}, 32'(clk_sel), 32'(ORIGIN));
        check({tag, "_state"}, 32'(state_o), 32'd0);
        check({tag, "_pulse"}, 32'(switch_pulse), 32'd0);
        check({tag, "_sat"}, 32'(err_sat), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int density;
        rst         = 1'b1;
        error_vec   = '0;
        auto_en     = 1'b1;
        force_sel   = 2'd0;
        err_sat_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_sel", 32'(clk_sel), 32'(ORIGIN));
        check("rst_pulse", 32'(switch_pulse), 32'd0);
        check("rst_sat", 32'(err_sat), 32'd0);
        check("rst_state", 32'(state_o), 32'd0);
        rst = 1'b0;

        // 1: clean traffic at origin never switches.
        run_clean(10);
        check("s1_sel", 32'(clk_sel), 32'd1);

        // 2: two errors on phase 1 step to phase 0; errors in HOLD ignored.
        cycle(3'b010, 1'b1, 2'd0, 1'b0);
        cycle(3'b010, 1'b1, 2'd0, 1'b0);
        check("s2_sel", 32'(clk_sel), 32'd0);
        check("s2_pulse", 32'(switch_pulse), 32'd1);
        for (int i = 0; i < HOLD_N + 1; i++) begin
            check("s2_hold_state", 32'(state_o), 32'd1);
            cycle(3'b111, 1'b1, 2'd0, 1'b0);
        end
        check("s2_back_track", 32'(state_o), 32'd0);
        check("s2_sel_kept", 32'(clk_sel), 32'd0);

        // 3: saturation at phase 0, clear, then set-beats-clear.
        cycle(3'b001, 1'b1, 2'd0, 1'b0);
        cycle(3'b001, 1'b1, 2'd0, 1'b0);
        check("s3_sat_set", 32'(err_sat), 32'd1);
        check("s3_sel", 32'(clk_sel), 32'd0);
        cycle(3'b000, 1'b1, 2'd0, 1'b1);
        check("s3_sat_clr", 32'(err_sat), 32'd0);
        cycle(3'b001, 1'b1, 2'd0, 1'b0);
        cycle(3'b001, 1'b1, 2'd0, 1'b1);
        check("s3_set_wins", 32'(err_sat), 32'd1);

        // 4: eight clean cycles recover to origin, then stay there.
        run_clean(7);
        check("s4_sel_pre", 32'(clk_sel), 32'd0);
        run_clean(1);
        check("s4_sel_rec", 32'(clk_sel), 32'd1);
        check("s4_pulse", 32'(switch_pulse), 32'd1);
        run_clean(HOLD_N + 1 + 20);
        check("s4_sel_hold", 32'(clk_sel), 32'd1);

        // 5: an error on the 7th clean cycle restarts the recovery count.
        cycle(3'b010, 1'b1, 2'd0, 1'b0);
        cycle(3'b010, 1'b1, 2'd0, 1'b0);
        run_clean(HOLD_N + 1);
        run_clean(6);
        cycle(3'b001, 1'b1, 2'd0, 1'b0);
        run_clean(7);
        check("s5_no_rec", 32'(clk_sel), 32'd0);
        run_clean(1);
        check("s5_rec", 32'(clk_sel), 32'd1);

        // 6: forced select with clamp, release into HOLD, reset mid-HOLD.
        run_clean(HOLD_N + 1);
        cycle(3'b000, 1'b0, 2'd3, 1'b0);
        check("s6_force_sel", 32'(clk_sel), 32'd2);
        check("s6_force_state", 32'(state_o), 32'd2);
        cycle(3'b000, 1'b1, 2'd0, 1'b0);
        check("s6_hold_state", 32'(state_o), 32'd1);
        check("s6_hold_sel", 32'(clk_sel), 32'd2);
        cycle(3'b000, 1'b1, 2'd0, 1'b0);
        async_reset("s6_rst");

        // Randomized traffic with varying error density.
        density = 1;
        for (int i = 0; i < 3000; i++) begin
            logic [NP-1:0] ev;
            logic          ae;
            if (i % 40 == 0) density = int'($urandom_range(0, 3));
            for (int b = 0; b < NP; b++) ev[b] = ($urandom_range(0, 7) < density);
            ae = ($urandom_range(0, 29) != 0);
            cycle(ev, ae, 2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 499) == 0) async_reset("rnd_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_sel_ctrl.md
Name: phase_sel_ctrl

Overview:
Parametrised N-phase clock-select controller for the MEDAC timing-error recovery path. It watches per-phase error flags from the shadow-latch detectors and walks the selected clock phase toward earlier (leading) phases on persistent error. After a clean interval it walks back toward the nominal (origin) phase. Its output drives the clock-phase mux select; it adds error thresholding, post-switch hold-off, recovery, saturation reporting and a forced-select mode.

Parameters:
NUM_PHASES, 3, number of selectable clock phases; index 0 = most leading, NUM_PHASES-1 = most lagging; legal range 2..16
ORIGIN_IDX, 1, nominal phase index selected out of reset; must be < NUM_PHASES
ERR_THRESH, 2, consecutive error cycles on the selected phase needed to step one phase earlier; legal range >= 1
RECOVER_CNT, 8, consecutive clean cycles needed to step one phase back toward ORIGIN_IDX; legal range >= 1
HOLDOFF, 4, cycles after any select change during which error_vec is ignored and counters stay cleared; legal range >= 0
SEL_W, derived as max(1, clog2(NUM_PHASES)), width of the select bus; localparam, not user-settable

Ports:
clk  in  1  block clock; all state updates on the falling edge
rst  in  1  asynchronous reset, active-high
error_vec  in  NUM_PHASES  per-phase timing-error flags; bit i = error seen on phase i
auto_en  in  1  1 = automatic tracking; 0 = forced select
force_sel  in  SEL_W  select used while auto_en=0; values >= NUM_PHASES clamp to NUM_PHASES-1
err_sat_clr  in  1  clears the sticky err_sat flag
clk_sel  out  SEL_W  registered phase select to the clock mux
switch_pulse  out  1  one-cycle pulse, high in the cycle clk_sel changed value
err_sat  out  1  sticky: error persisted while already at phase 0
state_o  out  2  current FSM state, for debug

Behaviour:
- Reset: while rst is high, all outputs and state hold their reset values: clk_sel=ORIGIN_IDX, switch_pulse=0, err_sat=0, state=TRACK, err_cnt=clean_cnt=hold_cnt=0. Reset is asynchronous. Reset mid-hold-off or mid-count discards all progress.
- Only error_vec[clk_sel] is evaluated. Bits for non-selected phases are ignored.
- All registers, including clk_sel, update on the negedge of clk. A decision is visible one negedge after the qualifying error sample. There is no combinational path from inputs to outputs.
- FSM states (2-bit encoding): TRACK=00, HOLD=01, FORCE=10. Encoding 11 is illegal and recovers to TRACK with clk_sel=ORIGIN_IDX.
- TRACK:
  - Error on the selected phase: increment err_cnt and clear clean_cnt.
    - When err_cnt reaches ERR_THRESH and clk_sel>0: clk_sel decrements, pulse switch_pulse, clear err_cnt, go to HOLD.
    - When err_cnt reaches ERR_THRESH and clk_sel==0: set err_sat, clear err_cnt, no switch, stay in TRACK.
  - No error: clear err_cnt and increment clean_cnt.
    - When clean_cnt reaches RECOVER_CNT and clk_sel<ORIGIN_IDX: increment clk_sel, pulse switch_pulse, clear clean_cnt, go to HOLD.
    - When clk_sel>=ORIGIN_IDX: clean_cnt saturates at RECOVER_CNT and no switch occurs. The block never steps later than ORIGIN_IDX automatically.
  - Error and recovery threshold in the same cycle: error wins and clean_cnt clears.
- HOLD:
  - hold_cnt counts up to HOLDOFF; error_vec is ignored and err_cnt/clean_cnt stay 0.
  - Returns to TRACK in the cycle hold_cnt==HOLDOFF. With HOLDOFF=0, HOLD lasts exactly one cycle.
- FORCE: entered from any state when auto_en=0.
  - clk_sel follows the clamped force_sel, registered.
  - switch_pulse fires on every change of clk_sel.
  - All counters are cleared.
  - When auto_en returns to 1: go to HOLD and keep the current clk_sel (no snap back to origin).
- err_sat:
  - Cleared by err_sat_clr.
  - If a set and err_sat_clr occur in the same cycle, set wins.
- Counter widths: clog2(max(ERR_THRESH, RECOVER_CNT, HOLDOFF)+1). Counters saturate and never wrap.

Decomposition:
- Package phase_ctrl_pkg: FSM state encodings TRACK/HOLD/FORCE and a clog2-based width helper function.
- One natural sub-module, phase_sel_cnt: a parametrised saturating up-counter with synchronous clear and a terminal-count flag. It is instantiated three times, for err_cnt, clean_cnt and hold_cnt.

Test Plan:
All scenarios use defaults (NUM_PHASES=3, ORIGIN_IDX=1, ERR_THRESH=2, RECOVER_CNT=8, HOLDOFF=4).
1. Reset then 10 clean cycles -> clk_sel=1, switch_pulse never high, state_o=00.
2. error_vec=3'b010 for 2 negedges -> clk_sel=0 on the 2nd negedge, one switch_pulse, state_o=01 for 5 cycles (hold_cnt 0 to 4). Errors injected during HOLD are ignored.
3. At clk_sel=0, error_vec=3'b001 for 2 cycles after hold-off -> err_sat=1, clk_sel stays 0. Pulse err_sat_clr -> err_sat=0. Assert error and clear together -> err_sat stays 1.
4. At clk_sel=0, 8 clean cycles after hold-off -> clk_sel=1 with a pulse. A further 20 clean cycles -> clk_sel stays 1.
5. Error on the 7th clean cycle -> clean_cnt clears and recovery needs a fresh 8 clean cycles.
6. auto_en=0, force_sel=3 -> clk_sel=2, state_o=10. auto_en=1 -> state_o=01 and clk_sel holds 2. Assert rst mid-HOLD -> clk_sel=1 immediately, without waiting for a clock edge.
